// File: rtl/rv_warp_sched_rr.sv
// Warp scheduler: tracks per-warp PC, thread mask and stall state, and issues
// one registered instruction-fetch request per grant (fixed-priority or round-robin).
module rv_warp_sched_rr #(
    parameter int unsigned CORE_ID      = 0,
    parameter int unsigned NUM_WARPS    = 4,
    parameter int unsigned NUM_THREADS  = 4,
    parameter int unsigned NUM_BARRIERS = 4,
    parameter logic [31:0] STARTUP_ADDR = 32'h8000_0000,
    parameter int unsigned SCHED_MODE   = 1,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned UUID_BITS    = 44,
    localparam int unsigned NWB = $clog2(NUM_WARPS),
    localparam int unsigned NBB = $clog2(NUM_BARRIERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             warp_ctl_if_valid,
    input  logic [NWB-1:0]                   warp_ctl_if_wid,
    input  logic                             warp_ctl_if_tmc_valid,
    input  logic [NUM_THREADS-1:0]           warp_ctl_if_tmc_tmask,
    input  logic                             warp_ctl_if_wspawn_valid,
    input  logic [NUM_WARPS-1:0]             warp_ctl_if_wspawn_wmask,
    input  logic [31:0]                      warp_ctl_if_wspawn_pc,
    input  logic                             warp_ctl_if_barrier_valid,
    input  logic [NBB-1:0]                   warp_ctl_if_barrier_id,
    input  logic [NWB-1:0]                   warp_ctl_if_barrier_size_m1,
    input  logic                             branch_ctl_if_valid,
    input  logic [NWB-1:0]                   branch_ctl_if_wid,
    input  logic                             branch_ctl_if_taken,
    input  logic [31:0]                      branch_ctl_if_dest,
    input  logic                             wstall_if_valid,
    input  logic [NWB-1:0]                   wstall_if_wid,
    input  logic                             wstall_if_stalled,
    input  logic                             ifetch_rsp_done,
    output logic                             ifetch_req_if_valid,
    input  logic                             ifetch_req_if_ready,
    output logic [UUID_BITS-1:0]             ifetch_req_if_uuid,
    output logic [NUM_THREADS-1:0]           ifetch_req_if_tmask,
    output logic [NWB-1:0]                   ifetch_req_if_wid,
    output logic [31:0]                      ifetch_req_if_PC,
    output logic [NUM_WARPS*NUM_THREADS-1:0] fetch_to_csr_if_thread_masks,
    output logic                             busy
);

    localparam int unsigned NUM_CORES    = 1;
    localparam int unsigned NUM_CLUSTERS = 1;
    localparam int unsigned NCW          = NWB + 1;

    logic [NUM_WARPS-1:0]                  r_active, r_stalled, r_spawn;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] r_tmask;
    logic [31:0]                           r_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0]                  r_bar [NUM_BARRIERS];
    logic [31:0]                           r_spawn_pc;
    logic [NWB-1:0]                        r_rr_ptr;
    logic [3:0]                            r_inflight;
    logic [UUID_BITS-1:0]                  r_issued;
    logic                                  r_run;
    logic                                  r_valid;
    logic [UUID_BITS-1:0]                  r_uuid;
    logic [NUM_THREADS-1:0]                r_out_tmask;
    logic [31:0]                           r_out_pc;
    logic [NWB-1:0]                        r_out_wid;

    logic [NUM_WARPS-1:0]   w_bar_any, w_ready;
    logic                   w_fire, w_sched, w_found;
    logic [4:0]             w_pending;
    logic [NWB-1:0]         w_grant_wid;
    logic [31:0]            w_grant_pc;
    logic [NUM_THREADS-1:0] w_grant_tmask;
    logic [UUID_BITS-1:0]   w_grant_uuid;
    logic [NCW-1:0]         w_bar_cnt;

    // Barrier occupancy: any warp waiting in any barrier is blocked.
    always_comb begin
        w_bar_any = '0;
        for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
            w_bar_any = w_bar_any | r_bar[NBB'(b)];
        end
        w_bar_cnt = '0;
        for (int j = 0; j < int'(NUM_WARPS); j++) begin
            w_bar_cnt = w_bar_cnt + NCW'(r_bar[warp_ctl_if_barrier_id][NWB'(j)]);
        end
    end

    assign w_ready   = r_active & ~r_stalled & ~w_bar_any;
    assign w_fire    = r_valid & ifetch_req_if_ready;
    // The request sitting in the output stage will become an outstanding fetch.
    assign w_pending = 5'(r_inflight) + 5'(r_valid);
    assign w_sched   = r_run & (|w_ready) & (~r_valid | ifetch_req_if_ready)
                     & (w_pending < 5'(MAX_INFLIGHT));

    // Pick a warp: lowest ready wid, or first ready wid after the last grant.
    always_comb begin
        logic [NWB-1:0] v_idx;
        v_idx       = '0;
        w_found     = 1'b0;
        w_grant_wid = '0;
        for (int i = 0; i < int'(NUM_WARPS); i++) begin
            v_idx = (SCHED_MODE == 0) ? NWB'(i) : r_rr_ptr + NWB'(i + 1);
            if (!w_found && w_ready[v_idx]) begin
                w_found     = 1'b1;
                w_grant_wid = v_idx;
            end
        end
    end

    // A warp whose previous fetch fires this cycle continues from that fetch's PC.
    assign w_grant_pc    = r_spawn[w_grant_wid] ? r_spawn_pc :
                           (w_fire && r_out_wid == w_grant_wid) ? r_out_pc + 32'd4 :
                           r_pc[w_grant_wid];
    assign w_grant_tmask = r_spawn[w_grant_wid] ? NUM_THREADS'(1) : r_tmask[w_grant_wid];
    assign w_grant_uuid  = r_issued * UUID_BITS'(NUM_CORES * NUM_CLUSTERS) + UUID_BITS'(CORE_ID);

    // Later writes in this block take precedence for the same warp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active    <= NUM_WARPS'(1);
            r_stalled   <= '0;
            r_spawn     <= '0;
            for (int j = 0; j < int'(NUM_WARPS); j++) begin
                r_tmask[NWB'(j)] <= (j == 0) ? NUM_THREADS'(1) : '0;
                r_pc[NWB'(j)]    <= (j == 0) ? STARTUP_ADDR : 32'd0;
            end
            for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
                r_bar[NBB'(b)] <= '0;
            end
            r_spawn_pc  <= '0;
            r_rr_ptr    <= NWB'(NUM_WARPS - 1);
            r_inflight  <= '0;
            r_issued    <= '0;
            r_run       <= 1'b0;
            r_valid     <= 1'b0;
            r_uuid      <= '0;
            r_out_tmask <= '0;
            r_out_pc    <= '0;
            r_out_wid   <= '0;
        end else begin
            // Scheduling is held off for the first cycle after reset release.
            r_run <= 1'b1;
            if (warp_ctl_if_valid && warp_ctl_if_wspawn_valid) begin
                r_active   <= warp_ctl_if_wspawn_wmask;
                r_spawn_pc <= warp_ctl_if_wspawn_pc;
                for (int j = 1; j < int'(NUM_WARPS); j++) begin
                    if (warp_ctl_if_wspawn_wmask[NWB'(j)]) begin
                        r_spawn[NWB'(j)] <= 1'b1;
                        r_tmask[NWB'(j)] <= NUM_THREADS'(1);
                    end
                end
            end
            if (warp_ctl_if_valid && warp_ctl_if_barrier_valid) begin
                r_stalled[warp_ctl_if_wid] <= 1'b0;
                if (w_bar_cnt == NCW'(warp_ctl_if_barrier_size_m1)) begin
                    r_bar[warp_ctl_if_barrier_id] <= '0;
                end else begin
                    r_bar[warp_ctl_if_barrier_id][warp_ctl_if_wid] <= 1'b1;
                end
            end
            if (warp_ctl_if_valid && warp_ctl_if_tmc_valid) begin
                r_tmask[warp_ctl_if_wid]   <= warp_ctl_if_tmc_tmask;
                r_active[warp_ctl_if_wid]  <= |warp_ctl_if_tmc_tmask;
                r_stalled[warp_ctl_if_wid] <= 1'b0;
            end
            if (branch_ctl_if_valid) begin
                r_stalled[branch_ctl_if_wid] <= 1'b0;
                if (branch_ctl_if_taken) begin
                    r_pc[branch_ctl_if_wid] <= branch_ctl_if_dest;
                end
            end
            if (w_sched) begin
                r_stalled[w_grant_wid] <= 1'b1;
                r_spawn[w_grant_wid]   <= 1'b0;
                r_rr_ptr               <= w_grant_wid;
                r_issued               <= r_issued + UUID_BITS'(1);
                r_valid                <= 1'b1;
                r_uuid                 <= w_grant_uuid;
                r_out_tmask            <= w_grant_tmask;
                r_out_pc               <= w_grant_pc;
                r_out_wid              <= w_grant_wid;
            end else if (w_fire) begin
                r_valid <= 1'b0;
            end
            if (w_fire) begin
                r_pc[r_out_wid] <= r_out_pc + 32'd4;
            end
            if (wstall_if_valid) begin
                r_stalled[wstall_if_wid] <= wstall_if_stalled;
            end
            // Outstanding fetches; a retire with nothing outstanding is dropped.
            if (w_fire && !(ifetch_rsp_done && r_inflight != 4'd0)) begin
                r_inflight <= r_inflight + 4'd1;
            end else if (!w_fire && ifetch_rsp_done && r_inflight != 4'd0) begin
                r_inflight <= r_inflight - 4'd1;
            end
        end
    end

    assign ifetch_req_if_valid          = r_valid;
    assign ifetch_req_if_uuid           = r_uuid;
    assign ifetch_req_if_tmask          = r_out_tmask;
    assign ifetch_req_if_wid            = r_out_wid;
    assign ifetch_req_if_PC             = r_out_pc;
    assign fetch_to_csr_if_thread_masks = r_tmask;
    assign busy                         = |r_active;

endmodule

// File: tb/tb_rv_warp_sched_rr.sv
// Directed bench for rv_warp_sched_rr: reset, hold, inflight limit, round-robin
// after spawn, barrier blocking/release, tmc deactivation and async reset.
module tb_rv_warp_sched_rr;

    logic        clk;
    logic        reset;
    logic        warp_ctl_if_valid;
    logic [1:0]  warp_ctl_if_wid;
    logic        warp_ctl_if_tmc_valid;
    logic [3:0]  warp_ctl_if_tmc_tmask;
    logic        warp_ctl_if_wspawn_valid;
    logic [3:0]  warp_ctl_if_wspawn_wmask;
    logic [31:0] warp_ctl_if_wspawn_pc;
    logic        warp_ctl_if_barrier_valid;
    logic [1:0]  warp_ctl_if_barrier_id;
    logic [1:0]  warp_ctl_if_barrier_size_m1;
    logic        branch_ctl_if_valid;
    logic [1:0]  branch_ctl_if_wid;
    logic        branch_ctl_if_taken;
    logic [31:0] branch_ctl_if_dest;
    logic        wstall_if_valid;
    logic [1:0]  wstall_if_wid;
    logic        wstall_if_stalled;
    logic        ifetch_rsp_done;
    logic        ifetch_req_if_valid;
    logic        ifetch_req_if_ready;
    logic [43:0] ifetch_req_if_uuid;
    logic [3:0]  ifetch_req_if_tmask;
    logic [1:0]  ifetch_req_if_wid;
    logic [31:0] ifetch_req_if_PC;
    logic [15:0] fetch_to_csr_if_thread_masks;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0]  rec_wid  [8];
    logic [31:0] rec_pc   [8];
    logic [43:0] rec_uuid [8];
    int          rec_n;

    logic [1:0]  exp_wid  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exp_pc   [5] = '{32'h100, 32'h100, 32'h100, 32'h8000_000C, 32'h104};

    rv_warp_sched_rr dut (
        .clk                          (clk),
        .reset                        (reset),
        .warp_ctl_if_valid            (warp_ctl_if_valid),
        .warp_ctl_if_wid              (warp_ctl_if_wid),
        .warp_ctl_if_tmc_valid        (warp_ctl_if_tmc_valid),
        .warp_ctl_if_tmc_tmask        (warp_ctl_if_tmc_tmask),
        .warp_ctl_if_wspawn_valid     (warp_ctl_if_wspawn_valid),
        .warp_ctl_if_wspawn_wmask     (warp_ctl_if_wspawn_wmask),
        .warp_ctl_if_wspawn_pc        (warp_ctl_if_wspawn_pc),
        .warp_ctl_if_barrier_valid    (warp_ctl_if_barrier_valid),
        .warp_ctl_if_barrier_id       (warp_ctl_if_barrier_id),
        .warp_ctl_if_barrier_size_m1  (warp_ctl_if_barrier_size_m1),
        .branch_ctl_if_valid          (branch_ctl_if_valid),
        .branch_ctl_if_wid            (branch_ctl_if_wid),
        .branch_ctl_if_taken          (branch_ctl_if_taken),
        .branch_ctl_if_dest           (branch_ctl_if_dest),
        .wstall_if_valid              (wstall_if_valid),
        .wstall_if_wid                (wstall_if_wid),
        .wstall_if_stalled            (wstall_if_stalled),
        .ifetch_rsp_done              (ifetch_rsp_done),
        .ifetch_req_if_valid          (ifetch_req_if_valid),
        .ifetch_req_if_ready          (ifetch_req_if_ready),
        .ifetch_req_if_uuid           (ifetch_req_if_uuid),
        .ifetch_req_if_tmask          (ifetch_req_if_tmask),
        .ifetch_req_if_wid            (ifetch_req_if_wid),
        .ifetch_req_if_PC             (ifetch_req_if_PC),
        .fetch_to_csr_if_thread_masks (fetch_to_csr_if_thread_masks),
        .busy                         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl_clear();
        warp_ctl_if_valid         = 1'b0;
        warp_ctl_if_tmc_valid     = 1'b0;
        warp_ctl_if_wspawn_valid  = 1'b0;
        warp_ctl_if_barrier_valid = 1'b0;
    endtask

    task automatic unstall(input logic [1:0] wid);
        wstall_if_valid   = 1'b1;
        wstall_if_wid     = wid;
        wstall_if_stalled = 1'b0;
        tick();
        wstall_if_valid   = 1'b0;
    endtask

    task automatic barrier_arrive(input logic [1:0] wid);
        warp_ctl_if_valid           = 1'b1;
        warp_ctl_if_wid             = wid;
        warp_ctl_if_barrier_valid   = 1'b1;
        warp_ctl_if_barrier_id      = 2'd1;
        warp_ctl_if_barrier_size_m1 = 2'd2;
        tick();
        ctl_clear();
    endtask

    task automatic tmc(input logic [1:0] wid, input logic [3:0] mask);
        warp_ctl_if_valid     = 1'b1;
        warp_ctl_if_wid       = wid;
        warp_ctl_if_tmc_valid = 1'b1;
        warp_ctl_if_tmc_tmask = mask;
        tick();
        ctl_clear();
    endtask

    // Reset must already be low; checks reset state and the first fetch of warp 0.
    task automatic release_reset();
        @(negedge clk);
        check("rst_valid", 64'(ifetch_req_if_valid), 64'd0);
        check("rst_tmasks", 64'(fetch_to_csr_if_thread_masks), 64'h0001);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel_busy", 64'(busy), 64'd1);
        tick();
        check("edge1_valid", 64'(ifetch_req_if_valid), 64'd0);
        tick();
        check("first_valid", 64'(ifetch_req_if_valid), 64'd1);
        check("first_wid", 64'(ifetch_req_if_wid), 64'd0);
        check("first_pc", 64'(ifetch_req_if_PC), 64'h8000_0000);
        check("first_tmask", 64'(ifetch_req_if_tmask), 64'd1);
        check("first_uuid", 64'(ifetch_req_if_uuid), 64'd0);
    endtask

    // Records every request that will fire at the coming edge; optionally unstalls it.
    task automatic run_window(input int cycles, input int stop_at, input bit do_unstall);
        rec_n = 0;
        for (int i = 0; i < cycles && rec_n < stop_at; i++) begin
            wstall_if_valid = 1'b0;
            if (ifetch_req_if_valid && ifetch_req_if_ready) begin
                if (rec_n < 8) begin
                    rec_wid[rec_n]  = ifetch_req_if_wid;
                    rec_pc[rec_n]   = ifetch_req_if_PC;
                    rec_uuid[rec_n] = ifetch_req_if_uuid;
                end
                rec_n++;
                if (do_unstall) begin
                    wstall_if_valid   = 1'b1;
                    wstall_if_wid     = ifetch_req_if_wid;
                    wstall_if_stalled = 1'b0;
                end
            end
            tick();
        end
        wstall_if_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        ctl_clear();
        warp_ctl_if_wid = '0;  warp_ctl_if_tmc_tmask = '0;
        warp_ctl_if_wspawn_wmask = '0;  warp_ctl_if_wspawn_pc = '0;
        warp_ctl_if_barrier_id = '0;  warp_ctl_if_barrier_size_m1 = '0;
        branch_ctl_if_valid = 1'b0;  branch_ctl_if_wid = '0;
        branch_ctl_if_taken = 1'b0;  branch_ctl_if_dest = '0;
        wstall_if_valid = 1'b0;  wstall_if_wid = '0;  wstall_if_stalled = 1'b0;
        ifetch_rsp_done = 1'b0;
        ifetch_req_if_ready = 1'b0;

        release_reset();

        // Output holds while not accepted.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(ifetch_req_if_valid), 64'd1);
            check("hold_wid", 64'(ifetch_req_if_wid), 64'd0);
            check("hold_pc", 64'(ifetch_req_if_PC), 64'h8000_0000);
            check("hold_uuid", 64'(ifetch_req_if_uuid), 64'd0);
        end
        ifetch_req_if_ready = 1'b1;
        tick();
        check("fire1_valid", 64'(ifetch_req_if_valid), 64'd0);

        // Second fetch, then the inflight limit blocks further grants.
        unstall(2'd0);
        tick();
        check("f2_valid", 64'(ifetch_req_if_valid), 64'd1);
        check("f2_pc", 64'(ifetch_req_if_PC), 64'h8000_0004);
        check("f2_uuid", 64'(ifetch_req_if_uuid), 64'd1);
        tick();
        unstall(2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("limit_valid", 64'(ifetch_req_if_valid), 64'd0);
        end
        ifetch_rsp_done = 1'b1;
        tick();
        ifetch_rsp_done = 1'b0;
        tick();
        check("f3_valid", 64'(ifetch_req_if_valid), 64'd1);
        check("f3_pc", 64'(ifetch_req_if_PC), 64'h8000_0008);
        check("f3_uuid", 64'(ifetch_req_if_uuid), 64'd2);
        tick();
        check("f3_fired", 64'(ifetch_req_if_valid), 64'd0);
        ifetch_rsp_done = 1'b1;
        repeat (3) tick();
        ifetch_rsp_done = 1'b0;

        // Spawn all warps and unstall each fetched warp: round-robin order.
        warp_ctl_if_valid        = 1'b1;
        warp_ctl_if_wid          = 2'd0;
        warp_ctl_if_wspawn_valid = 1'b1;
        warp_ctl_if_wspawn_wmask = 4'b1111;
        warp_ctl_if_wspawn_pc    = 32'h100;
        wstall_if_valid          = 1'b1;
        wstall_if_wid            = 2'd0;
        wstall_if_stalled        = 1'b0;
        tick();
        ctl_clear();
        wstall_if_valid = 1'b0;
        check("spawn_tmasks", 64'(fetch_to_csr_if_thread_masks), 64'h1111);
        check("spawn_busy", 64'(busy), 64'd1);
        ifetch_rsp_done = 1'b1;
        run_window(40, 5, 1'b1);
        check("rr_count", 64'(rec_n), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_wid%0d", k), 64'(rec_wid[k]), 64'(exp_wid[k]));
            check($sformatf("rr_pc%0d", k), 64'(rec_pc[k]), 64'(exp_pc[k]));
            check($sformatf("rr_uuid%0d", k), 64'(rec_uuid[k]), 64'(k + 3));
        end

        // Asynchronous reset while a request is pending.
        ifetch_req_if_ready = 1'b0;
        check("pre_rst_valid", 64'(ifetch_req_if_valid), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(ifetch_req_if_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd1);
        release_reset();

        // Barrier 1 with three participants.
        warp_ctl_if_valid        = 1'b1;
        warp_ctl_if_wid          = 2'd0;
        warp_ctl_if_wspawn_valid = 1'b1;
        warp_ctl_if_wspawn_wmask = 4'b0111;
        warp_ctl_if_wspawn_pc    = 32'h200;
        tick();
        ctl_clear();
        barrier_arrive(2'd0);
        barrier_arrive(2'd1);
        ifetch_req_if_ready = 1'b1;
        run_window(8, 8, 1'b0);
        check("bar_blk_count", 64'(rec_n), 64'd2);
        check("bar_blk_wid0", 64'(rec_wid[0]), 64'd0);
        check("bar_blk_pc0", 64'(rec_pc[0]), 64'h8000_0000);
        check("bar_blk_wid1", 64'(rec_wid[1]), 64'd2);
        check("bar_blk_pc1", 64'(rec_pc[1]), 64'h200);
        check("bar_blk_uuid1", 64'(rec_uuid[1]), 64'd1);
        barrier_arrive(2'd2);
        run_window(10, 8, 1'b0);
        check("bar_rel_count", 64'(rec_n), 64'd3);
        check("bar_rel_wid0", 64'(rec_wid[0]), 64'd0);
        check("bar_rel_pc0", 64'(rec_pc[0]), 64'h8000_0004);
        check("bar_rel_wid1", 64'(rec_wid[1]), 64'd1);
        check("bar_rel_pc1", 64'(rec_pc[1]), 64'h200);
        check("bar_rel_wid2", 64'(rec_wid[2]), 64'd2);
        check("bar_rel_pc2", 64'(rec_pc[2]), 64'h204);
        check("bar_rel_uuid2", 64'(rec_uuid[2]), 64'd4);
        ifetch_rsp_done = 1'b0;

        // Deactivate warps one by one through tmc.
        tmc(2'd1, 4'b0000);
        check("tmc1_busy", 64'(busy), 64'd1);
        tmc(2'd2, 4'b0000);
        check("tmc2_busy", 64'(busy), 64'd1);
        tmc(2'd0, 4'b0000);
        check("tmc0_busy", 64'(busy), 64'd0);
        check("tmc0_tmasks", 64'(fetch_to_csr_if_thread_masks), 64'h0000);
        check("tmc0_valid", 64'(ifetch_req_if_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_warp_sched_rr.md
RV_WARP_SCHED_RR -- requirements
Module: RV_warp_sched_rr

Interface
REQ-001 Parameters, one per line:
- CORE_ID, 0, core index used in UUID generation
- NUM_WARPS, 4, warp count (power of two, >=2)
- NUM_THREADS, 4, threads per warp
- NUM_BARRIERS, 4, barrier table entries
- STARTUP_ADDR, 32'h8000_0000, warp-0 reset PC
- SCHED_MODE, 1, 0 = fixed priority (lowest wid), 1 = round-robin
- MAX_INFLIGHT, 2, maximum outstanding fetches (1..15)
- UUID_BITS, 44, instruction UUID width
REQ-002 Ports, one per line (NWB = log2 NUM_WARPS, NBB = log2 NUM_BARRIERS):
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- warp_ctl_if_valid  in  1  control op valid
- warp_ctl_if_wid  in  NWB  target warp
- warp_ctl_if_tmc_valid / warp_ctl_if_tmc_tmask  in  1 / NUM_THREADS  thread-mask update
- warp_ctl_if_wspawn_valid / _wmask / _pc  in  1 / NUM_WARPS / 32  spawn warps
- warp_ctl_if_barrier_valid / _id / _size_m1  in  1 / NBB / NWB  barrier arrive
- branch_ctl_if_valid / _wid / _taken / _dest  in  1 / NWB / 1 / 32  branch resolve
- wstall_if_valid / _wid / _stalled  in  1 / NWB / 1  decode stall status
- ifetch_rsp_done  in  1  one outstanding fetch retired
- ifetch_req_if_valid  out  1  fetch request
- ifetch_req_if_ready  in  1  fetch accept
- ifetch_req_if_uuid  out  UUID_BITS  instruction UUID
- ifetch_req_if_tmask  out  NUM_THREADS  thread mask
- ifetch_req_if_wid  out  NWB  warp id
- ifetch_req_if_PC  out  32  fetch PC
- fetch_to_csr_if_thread_masks  out  NUM_WARPS*NUM_THREADS  all thread masks, warp j at bits [j*NUM_THREADS +: NUM_THREADS]
- busy  out  1  any warp active

Function
REQ-003 ready = active & ~stalled & ~(OR of all barrier masks); schedule only if some warp is ready, output stage is free (not valid or ready=1), and inflight < MAX_INFLIGHT.
REQ-004 SCHED_MODE=0: grant lowest ready wid.
REQ-005 SCHED_MODE=1: search starts at rr_ptr+1 and wraps modulo NUM_WARPS; rr_ptr updates to the granted wid on each grant only.
REQ-006 Grant registers {valid, uuid, tmask, PC, wid} into the output stage in the next cycle (1-cycle latency); while valid=1 and ready=0 all outputs hold stable.
REQ-007 Granted warp: stalled=1; PC advances +4 on fire; uuid = issued*NUM_CORES*NUM_CLUSTERS + CORE_ID, where issued is an incrementing counter per grant.
REQ-008 inflight counter (4 bits): +1 on fire, -1 on ifetch_rsp_done; both in one cycle: unchanged; done at 0 is ignored; never exceeds MAX_INFLIGHT.
REQ-009 wspawn: active=wmask; each spawned warp except 0 issues its first fetch with the wspawn PC and tmask=1; the spawn flag clears on that warp's grant.
REQ-010 tmc: thread_mask[wid]=tmask; active[wid]=(tmask!=0); stalled[wid]=0.
REQ-011 barrier: stalled[wid]=0; if popcount(mask[id])==size_m1, clear mask[id] (release all), else set mask[id][wid].
REQ-012 branch: stalled[wid]=0; taken -> PC[wid]=dest.
REQ-013 wstall: stalled[wid]=_stalled.
REQ-014 Same-warp same-cycle conflict precedence, low to high: wspawn, barrier, tmc, branch, grant, fetch PC+4, wstall; the highest applicable write wins.
REQ-015 busy = (active != 0).

Reset
REQ-016 Reset asserts asynchronously at any time, including mid-handshake, and forces:
- ifetch_req_if_valid=0
- inflight=0, issued=0, rr_ptr=NUM_WARPS-1
- barriers, stalled, spawn flags cleared
- active=1 (warp 0 only); thread_mask[0]=1, others 0
- PC[0]=STARTUP_ADDR, others 0
REQ-017 After deassertion: busy=1 immediately; first fetch is wid 0, PC=STARTUP_ADDR, valid in the second clock edge after deassertion.

Verification
REQ-018 Reset release, ready=1 -> wid 0, PC=0x8000_0000, tmask=1, uuid=CORE_ID.
REQ-019 wspawn wmask=4'b1111, pc=0x100, wstall clears each warp, SCHED_MODE=1 -> grants 1,2,3,0,1...; warps 1-3 first PC=0x100.
REQ-020 MAX_INFLIGHT=2, no ifetch_rsp_done -> exactly 2 fires then valid stays 0; one done pulse -> exactly one more fire.
REQ-021 ready=0 for 5 cycles with valid=1 -> wid/PC/uuid unchanged; no PC advance or extra grant.
REQ-022 Barrier id=1, size_m1=2: warps 0,1 arrive -> both blocked; warp 2 arrives -> mask[1]=0, all schedulable.
REQ-023 tmc tmask=0 on last active warp -> busy=0 next cycle; reset asserted mid-fetch -> valid=0 without a clock edge.
